sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 82 ++++++++
 tb/tb_sync_fifo_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, level flags and error pulses
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush of pointers, count and error pulses
//   wr / datain  write request and data
//   rd / dataout read request and registered read data (valid one cycle after rd)
//   full / empty / almost_full / almost_empty  decoded from the registered count
//   count        occupancy 0..DEPTH
//   overflow / underflow  one-cycle pulses after a rejected write / read
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          datain,
  input  logic                       rd,
  output logic [DATA_W-1:0]          dataout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_ok, rd_ok;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign count        = count_q;
  assign dataout      = dataout_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
  // An empty FIFO never bypasses: the write lands, the read is rejected.
  always_comb begin
    rd_ok       = rd && !empty && !clr;
    wr_ok       = wr && (!full || rd) && !clr;
    overflow_d  = wr && full && !rd && !clr;
    underflow_d = rd && empty && !clr;
    dataout_d   = rd_ok ? mem_q[rd_ptr_q] : dataout_q;
    wr_ptr_d    = clr ? '0 : wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = clr ? '0 : rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = clr               ? '0 :
                  (wr_ok && !rd_ok) ? count_q + CW'(1) :
                  (rd_ok && !wr_ok) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dataout_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dataout_q   <= dataout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= datain;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (8x16)
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst_n, clr, wr, rd;
  logic [7:0] datain, dataout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int         checks = 0;
  int         failures = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .datain(datain), .rd(rd),
    .dataout(dataout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, dataout} !== {5'd0, 4'b1100, 2'b00, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b uf=%b do=%h want cnt=0 e=1 ae=1 f=0 af=0 ov=0 uf=0 do=00",
               count, empty, almost_empty, full, almost_full, overflow, underflow, dataout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      datain = 8'(i);
      tick();
      checks++;
      if ({count, almost_full, full} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16)}) begin
        failures++;
        $display("FAIL fill_%0d got cnt=%0d af=%b f=%b want cnt=%0d af=%b f=%b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    datain = 8'hAA;
    tick();
    wr = 1'b0;
    checks++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin
      failures++;
      $display("FAIL overflow_pulse got ov=%b cnt=%0d want ov=1 cnt=16", overflow, count);
    end
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_one_cycle got ov=%b want 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1;
      tick();
      checks++;
      if ({dataout, count, almost_empty} !== {8'(i), 5'(15 - i), (15 - i <= 2)}) begin
        failures++;
        $display("FAIL drain_%0d got do=%h cnt=%0d ae=%b want do=%h cnt=%0d ae=%b",
                 i, dataout, count, almost_empty, 8'(i), 15 - i, (15 - i <= 2));
      end
    end
    tick();
    rd = 1'b0;
    checks++;
    if ({underflow, empty, dataout} !== {1'b1, 1'b1, 8'd15}) begin
      failures++;
      $display("FAIL underflow_pulse got uf=%b e=%b do=%h want uf=1 e=1 do=0f", underflow, empty, dataout);
    end
    tick();
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_one_cycle got uf=%b want 0", underflow);
    end
  endtask

  task automatic test_stream();
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      datain = 8'(100 + i);
      tick();
    end
    rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      datain = 8'(103 + k);
      tick();
      checks++;
      if ({count, dataout, overflow, underflow} !== {5'd3, 8'(100 + k), 2'b00}) begin
        failures++;
        $display("FAIL stream_%0d got cnt=%0d do=%0d ov=%b uf=%b want cnt=3 do=%0d ov=0 uf=0",
                 k, count, dataout, overflow, underflow, 100 + k);
      end
    end
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dataout !== 8'(140 + i)) begin
        failures++;
        $display("FAIL stream_tail_%0d got do=%0d want %0d", i, dataout, 140 + i);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_simul();
    wr = 1'b1;
    rd = 1'b1;
    datain = 8'h55;
    tick();
    rd = 1'b0;
    checks++;
    if ({count, underflow, dataout} !== {5'd1, 1'b1, 8'd142}) begin
      failures++;
      $display("FAIL simul_empty got cnt=%0d uf=%b do=%0d want cnt=1 uf=1 do=142", count, underflow, dataout);
    end
    for (int i = 0; i < 15; i++) begin
      datain = 8'(8'h60 + i);
      tick();
    end
    rd = 1'b1;
    datain = 8'h77;
    tick();
    wr = 1'b0;
    checks++;
    if ({count, full, dataout, overflow} !== {5'd16, 1'b1, 8'h55, 1'b0}) begin
      failures++;
      $display("FAIL simul_full got cnt=%0d f=%b do=%h ov=%b want cnt=16 f=1 do=55 ov=0", count, full, dataout, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (dataout !== ((i < 15) ? 8'(8'h60 + i) : 8'h77)) begin
        failures++;
        $display("FAIL simul_drain_%0d got do=%h want %h", i, dataout, (i < 15) ? 8'(8'h60 + i) : 8'h77);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_clr();
    wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      datain = 8'(8'h90 + i);
      tick();
    end
    checks++;
    if (count !== 5'd9) begin
      failures++;
      $display("FAIL clr_setup got cnt=%0d want 9", count);
    end
    clr = 1'b1;
    datain = 8'hEE;
    tick();
    wr = 1'b0;
    checks++;
    if ({count, empty, dataout} !== {5'd0, 1'b1, 8'h77}) begin
      failures++;
      $display("FAIL clr_flush got cnt=%0d e=%b do=%h want cnt=0 e=1 do=77", count, empty, dataout);
    end
    rd = 1'b1;
    tick();
    clr = 1'b0;
    rd = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_underflow got uf=%b want 0", underflow);
    end
    wr = 1'b1;
    datain = 8'h31;
    tick();
    wr = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if ({dataout, count} !== {8'h31, 5'd0}) begin
      failures++;
      $display("FAIL clr_after got do=%h cnt=%0d want do=31 cnt=0", dataout, count);
    end
  endtask

  task automatic test_async_reset();
    wr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      datain = 8'(8'hA0 + i);
      tick();
    end
    wr = 1'b0;
    checks++;
    if (count !== 5'd7) begin
      failures++;
      $display("FAIL areset_setup got cnt=%0d want 7", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, dataout} !== {5'd0, 4'b1100, 2'b00, 8'h00}) begin
      failures++;
      $display("FAIL areset_immediate got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b uf=%b do=%h want cnt=0 e=1 ae=1 f=0 af=0 ov=0 uf=0 do=00",
               count, empty, almost_empty, full, almost_full, overflow, underflow, dataout);
    end
    #1;
    rst_n = 1'b1;
    tick();
    wr = 1'b1;
    datain = 8'hC1;
    tick();
    datain = 8'hC2;
    tick();
    wr = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if ({dataout, count} !== {8'hC1, 5'd1}) begin
      failures++;
      $display("FAIL areset_first_word got do=%h cnt=%0d want do=c1 cnt=1", dataout, count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    datain = '0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_simul();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
